// File: rtl/list_pkg.sv
// Shared types for the linked-list pointer memory:
// node pointer width, null terminator and chain-builder states.
package list_pkg;
  localparam int n = 16;
  localparam int Width = $clog2(n);

  typedef logic [Width-1:0] Pointer;

  localparam Pointer NULL_PTR = '0;

  typedef enum logic [1:0] {
    IDLE,
    OPEN,
    TERM
  } state_t;
endpackage

// File: rtl/ptr_fifo.sv
// Small show-ahead FIFO of completed chain heads.
// dout is forced to null whenever the FIFO is empty.
module ptr_fifo
  import list_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  Pointer      din,
  output logic        full,
  input  logic        pop,
  output Pointer      dout,
  output logic        vld,
  output logic [AW:0] count
);
  Pointer        mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign vld     = count != '0;
  assign dout    = vld ? mem[rp] : NULL_PTR;
  assign do_pop  = pop && vld;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end
endmodule

// File: rtl/chain_builder.sv
// Writes the next-pointer table from a stream of chained node
// pointers and publishes each completed chain head.
module chain_builder
  import list_pkg::*;
#(
  parameter int HEAD_DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  Pointer in_ptr,
  input  logic   in_last,
  input  logic   in_vld,
  output logic   in_rdy,
  output logic   wr_en,
  output Pointer wr_addr,
  output Pointer wr_data,
  output Pointer start,
  output logic   start_vld,
  input  logic   start_rdy,
  output logic   err_null
);
  localparam int CW = $clog2(HEAD_DEPTH) + 1;

  state_t          state;
  Pointer          head;
  Pointer          prev;
  logic            push_q;
  Pointer          push_din;
  logic            fifo_full;
  logic [CW-1:0]   fifo_cnt;
  logic            busy;
  logic            acc;
  logic            acc_node;

  // A head still in the push register already owns a FIFO slot.
  assign busy = fifo_full ||
    (push_q && fifo_cnt == CW'(HEAD_DEPTH - 1));

  assign in_rdy   = rst_n && state != TERM && !busy;
  assign acc      = in_vld && in_rdy;
  assign acc_node = acc && in_ptr != NULL_PTR;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      head     <= NULL_PTR;
      prev     <= NULL_PTR;
      wr_en    <= 1'b0;
      wr_addr  <= NULL_PTR;
      wr_data  <= NULL_PTR;
      push_q   <= 1'b0;
      push_din <= NULL_PTR;
      err_null <= 1'b0;
    end else begin
      wr_en  <= 1'b0;
      push_q <= 1'b0;
      if (acc && in_ptr == NULL_PTR) err_null <= 1'b1;
      unique case (state)
        IDLE: begin
          if (acc_node) begin
            if (in_last) begin
              wr_en    <= 1'b1;
              wr_addr  <= in_ptr;
              wr_data  <= NULL_PTR;
              push_q   <= 1'b1;
              push_din <= in_ptr;
            end else begin
              head  <= in_ptr;
              prev  <= in_ptr;
              state <= OPEN;
            end
          end
        end
        OPEN: begin
          if (acc_node) begin
            wr_en   <= 1'b1;
            wr_addr <= prev;
            wr_data <= in_ptr;
            prev    <= in_ptr;
            if (in_last) state <= TERM;
          end
        end
        TERM: begin
          wr_en    <= 1'b1;
          wr_addr  <= prev;
          wr_data  <= NULL_PTR;
          push_q   <= 1'b1;
          push_din <= head;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  ptr_fifo #(.DEPTH(HEAD_DEPTH)) u_heads (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_q),
    .din   (push_din),
    .full  (fifo_full),
    .pop   (start_rdy),
    .dout  (start),
    .vld   (start_vld),
    .count (fifo_cnt)
  );
endmodule
